// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the pipelined one-hot decoder tree:
//   MODE_DIRECT / MODE_SCAN : values of the 'mode' input sampled with 'start'
//   state_t                 : sequencer states (idle, issuing scan, draining)
//   sel_w_legal()           : elaboration-time check of the select width
// ---------------------------------------------------------------------------
package dec_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The tree consumes the select two bits per level, so the width must be
    // a positive even number.
    function automatic bit sel_w_legal(input int w);
        return (w >= 2) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/dec2_4_en.sv
// ---------------------------------------------------------------------------
// dec2_4_en
// Combinational 2:4 one-hot decoder with enable. Building block of every
// level of the decoder tree.
//   sel : 2-bit select
//   en  : enable; when low the output is all zeros
//   y   : one-hot result, bit 'sel' set when enabled
// ---------------------------------------------------------------------------
module dec2_4_en (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    assign y = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/decoder_tree_pipe.sv
// ---------------------------------------------------------------------------
// decoder_tree_pipe
// Pipelined SEL_W : 2**SEL_W one-hot decoder built as a tree of 2:4 enable
// decoders, one register stage per tree level. Direct requests enter through
// a valid/ready handshake; a self-driven scan walks the one-hot output across
// every position.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_valid   : direct request valid
//   in_ready   : direct request accepted when in_valid && in_ready
//   d, en      : select value and enable, captured with an accepted request
//   mode       : 0 = direct, 1 = scan; only looked at together with start
//   start      : single-cycle pulse that launches a scan
//   y          : registered one-hot (or zero for an en=0 beat)
//   out_valid  : y carries a beat this cycle
//   busy       : scan issuing or draining
//   done       : pulse coincident with the final scan beat
// ---------------------------------------------------------------------------
module decoder_tree_pipe
    import dec_pkg::*;
#(
    parameter  int SEL_W = 4,
    localparam int OUT_W = 2 ** SEL_W,
    localparam int LVL   = SEL_W / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] d,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    output logic [OUT_W-1:0] y,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    if (!sel_w_legal(SEL_W)) begin : g_bad_sel_w
        $error("decoder_tree_pipe: SEL_W must be even and >= 2");
    end

    localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(OUT_W - 1);

    state_t           state;
    logic [SEL_W-1:0] count;
    logic [SEL_W-1:0] d_q;
    logic             en_q;
    logic             in_valid_q;

    logic             scan_req;
    logic             accept;
    logic             cnt_last;
    logic             drain_exit;

    logic [SEL_W-1:0] src_sel;
    logic             src_en;
    logic             src_valid;
    logic             src_last;

    // A scan request wins the cycle it arrives, so the handshake refuses any
    // direct beat offered alongside it.
    assign scan_req = (state == ST_IDLE) && start && (mode == MODE_SCAN);
    assign in_ready = (state == ST_IDLE) && !(start && (mode == MODE_SCAN));
    assign accept   = in_valid && in_ready;
    assign cnt_last = (count == CNT_LAST);
    assign busy     = (state != ST_IDLE);

    // Accepted direct requests are captured here first. This register plays
    // the same role for direct beats that the scan counter plays for scan
    // beats, which is why a direct beat accepted just before a start lands
    // on y exactly one cycle ahead of the first scan beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            d_q        <= '0;
            en_q       <= 1'b0;
        end else begin
            in_valid_q <= accept;
            if (accept) begin
                d_q  <= d;
                en_q <= en;
            end
        end
    end

    // Sequencer: idle until a scan start, then issue one beat per cycle from
    // the counter, then wait for the tagged last beat to reach the output
    // stage. With a single level the last beat is already at the output when
    // it is issued, so there is nothing to drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_req) begin
                        state <= ST_SCAN;
                        count <= '0;
                    end
                end
                ST_SCAN: begin
                    if (cnt_last) begin
                        state <= (LVL == 1) ? ST_IDLE : ST_DRAIN;
                    end else begin
                        count <= count + SEL_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_exit) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Source of the beat entering level 0: the scan counter while scanning,
    // otherwise the captured direct request.
    always_comb begin
        src_sel   = d_q;
        src_en    = en_q;
        src_valid = in_valid_q;
        src_last  = 1'b0;
        if (state == ST_SCAN) begin
            src_sel   = count;
            src_en    = 1'b1;
            src_valid = 1'b1;
            src_last  = cnt_last;
        end
    end

    // Decoder tree. Level k holds a 4**(k+1)-bit partial one-hot plus the
    // select bits not yet consumed. Each set bit of level k-1 enables one
    // 2:4 sub-decoder, so index = 4*parent + pair and the select is decoded
    // MSB pair first. Stages only load on a valid beat so y holds between
    // beats; valid and the last-beat tag always advance.
    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int VW = 4 ** (k + 1);
        localparam int RW = SEL_W - 2 * (k + 1);

        logic [VW-1:0] vec_d;
        logic [VW-1:0] vec_q;
        logic          valid_d;
        logic          valid_q;
        logic          last_d;
        logic          last_q;

        if (k == 0) begin : g_root
            dec2_4_en u_dec (
                .sel (src_sel[SEL_W-1 -: 2]),
                .en  (src_en),
                .y   (vec_d)
            );
            assign valid_d = src_valid;
            assign last_d  = src_last;
        end else begin : g_node
            logic [1:0] pair;
            assign pair = g_lvl[k-1].g_rem.rem_q[RW+1 -: 2];
            for (genvar j = 0; j < 4 ** k; j++) begin : g_sub
                dec2_4_en u_dec (
                    .sel (pair),
                    .en  (g_lvl[k-1].vec_q[j]),
                    .y   (vec_d[4*j +: 4])
                );
            end
            assign valid_d = g_lvl[k-1].valid_q;
            assign last_d  = g_lvl[k-1].last_q;
        end

        if (k < LVL - 1) begin : g_rem
            logic [RW-1:0] rem_d;
            logic [RW-1:0] rem_q;
            if (k == 0) begin : g_from_src
                assign rem_d = src_sel[RW-1:0];
            end else begin : g_from_prev
                assign rem_d = g_lvl[k-1].g_rem.rem_q[RW-1:0];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_q <= '0;
                end else if (valid_d) begin
                    rem_q <= rem_d;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vec_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                valid_q <= valid_d;
                last_q  <= valid_d && last_d;
                if (valid_d) begin
                    vec_q <= vec_d;
                end
            end
        end
    end

    // The drain ends on the edge at which the tagged last beat moves into
    // the output stage, so busy falls in the same cycle done rises.
    if (LVL > 1) begin : g_drain
        assign drain_exit = g_lvl[LVL-2].last_q;
    end else begin : g_no_drain
        assign drain_exit = 1'b0;
    end

    assign y         = g_lvl[LVL-1].vec_q;
    assign out_valid = g_lvl[LVL-1].valid_q;
    assign done      = g_lvl[LVL-1].last_q;

endmodule

// File: tb/tb_decoder_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder_tree_pipe
// Self-checking bench for decoder_tree_pipe. Two instances share the clock
// and reset: a 4-bit select build (latency 2) and a 6-bit build (latency 3).
// Direct beats come from a vector table; scans, reset during a scan and the
// wide build use hand-written sequences.
// ---------------------------------------------------------------------------
module tb_decoder_tree_pipe;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 4-bit select instance
    logic        in_valid4, start4, mode4, en4;
    logic [3:0]  d4;
    logic        in_ready4, out_valid4, busy4, done4;
    logic [15:0] y4;

    // 6-bit select instance
    logic        in_valid6, start6, mode6, en6;
    logic [5:0]  d6;
    logic        in_ready6, out_valid6, busy6, done6;
    logic [63:0] y6;

    decoder_tree_pipe #(.SEL_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .d         (d4),
        .en        (en4),
        .mode      (mode4),
        .start     (start4),
        .y         (y4),
        .out_valid (out_valid4),
        .busy      (busy4),
        .done      (done4)
    );

    decoder_tree_pipe #(.SEL_W(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .d         (d6),
        .en        (en6),
        .mode      (mode6),
        .start     (start6),
        .y         (y6),
        .out_valid (out_valid6),
        .busy      (busy6),
        .done      (done6)
    );

    typedef struct {
        logic [3:0]  d;
        logic        en;
        logic [15:0] y;
    } vec_t;

    vec_t vecs [7];
    int   tests    = 0;
    int   failures = 0;

    // One comparison: bumps the counters and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive the 4-bit instance inputs.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic e,
                                 input logic s, input logic m);
        in_valid4 = v;
        d4        = d;
        en4       = e;
        start4    = s;
        mode4     = m;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;

        vecs[0] = '{4'hA, 1'b1, 16'h0400};
        vecs[1] = '{4'h0, 1'b1, 16'h0001};
        vecs[2] = '{4'hF, 1'b1, 16'h8000};
        vecs[3] = '{4'h5, 1'b1, 16'h0020};
        vecs[4] = '{4'h3, 1'b0, 16'h0000};
        vecs[5] = '{4'h7, 1'b1, 16'h0080};
        vecs[6] = '{4'hC, 1'b1, 16'h1000};

        // Reset both instances with idle inputs.
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        in_valid6 = 1'b0; d6 = '0; en6 = 1'b0; start6 = 1'b0; mode6 = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checkOutput("reset y", 64'(y4), 64'h0);
        checkOutput("reset out_valid", 64'(out_valid4), 64'h0);
        checkOutput("reset in_ready", 64'(in_ready4), 64'h1);
        checkOutput("reset busy", 64'(busy4), 64'h0);
        checkOutput("reset done", 64'(done4), 64'h0);
        checkOutput("reset y6", y6, 64'h0);
        checkOutput("reset out_valid6", 64'(out_valid6), 64'h0);

        // Back-to-back direct beats; each appears two edges after acceptance.
        for (int i = 0; i < 9; i++) begin
            if (i < 7) applyStimulus(1'b1, vecs[i].d, vecs[i].en, 1'b0, 1'b0);
            else       applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("direct in_ready %0d", i), 64'(in_ready4), 64'h1);
            step();
            if (i >= 2) begin
                checkOutput($sformatf("direct y %0d", i - 2), 64'(y4), 64'(vecs[i-2].y));
                checkOutput($sformatf("direct out_valid %0d", i - 2), 64'(out_valid4), 64'h1);
            end else begin
                checkOutput($sformatf("direct early out_valid %0d", i), 64'(out_valid4), 64'h0);
            end
        end
        step();
        checkOutput("direct valid drops", 64'(out_valid4), 64'h0);
        checkOutput("direct y holds", 64'(y4), 64'h1000);

        // start with mode=0 is ignored and the direct beat goes through.
        applyStimulus(1'b1, 4'h2, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("start mode0 in_ready", 64'(in_ready4), 64'h1);
        step();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("start mode0 busy", 64'(busy4), 64'h0);
        step();
        step();
        checkOutput("start mode0 y", 64'(y4), 64'h0004);
        checkOutput("start mode0 out_valid", 64'(out_valid4), 64'h1);
        step();

        // Direct beat just before a scan start, then a full 16-beat scan
        // with an ignored start pulse in the middle.
        applyStimulus(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 4'h9, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("scan start in_ready", 64'(in_ready4), 64'h0);
        step();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("scan busy rises", 64'(busy4), 64'h1);
        checkOutput("scan in_ready low", 64'(in_ready4), 64'h0);
        step();
        checkOutput("pre-scan direct y", 64'(y4), 64'h0040);
        checkOutput("pre-scan direct valid", 64'(out_valid4), 64'h1);
        for (int k = 0; k < 16; k++) begin
            step();
            checkOutput($sformatf("scan y %0d", k), 64'(y4), 64'd1 << k);
            checkOutput($sformatf("scan valid %0d", k), 64'(out_valid4), 64'h1);
            checkOutput($sformatf("scan done %0d", k), 64'(done4), 64'(k == 15));
            checkOutput($sformatf("scan busy %0d", k), 64'(busy4), 64'(k != 15));
            checkOutput($sformatf("scan in_ready %0d", k), 64'(in_ready4), 64'(k == 15));
            if (k == 7) applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
            else        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        end
        step();
        checkOutput("scan end valid", 64'(out_valid4), 64'h0);
        checkOutput("scan end done", 64'(done4), 64'h0);
        checkOutput("scan end busy", 64'(busy4), 64'h0);

        // Reset after the fifth scan beat.
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("abort scan y %0d", k), 64'(y4), 64'd1 << k);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort y", 64'(y4), 64'h0);
        checkOutput("abort out_valid", 64'(out_valid4), 64'h0);
        checkOutput("abort busy", 64'(busy4), 64'h0);
        checkOutput("abort done", 64'(done4), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done4 !== 1'b0 || out_valid4 !== 1'b0 || busy4 !== 1'b0) seen++;
        end
        checkOutput("abort no stray beats", 64'(seen), 64'h0);
        applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("post-abort early valid", 64'(out_valid4), 64'h0);
        step();
        checkOutput("post-abort y", 64'(y4), 64'h0002);
        checkOutput("post-abort valid", 64'(out_valid4), 64'h1);

        // Wide build: direct beat with latency 3, then a 64-beat scan.
        in_valid6 = 1'b1; d6 = 6'd37; en6 = 1'b1;
        step();
        in_valid6 = 1'b0; d6 = '0; en6 = 1'b0;
        step();
        checkOutput("w6 direct early valid a", 64'(out_valid6), 64'h0);
        step();
        checkOutput("w6 direct early valid b", 64'(out_valid6), 64'h0);
        step();
        checkOutput("w6 direct y", y6, 64'd1 << 37);
        checkOutput("w6 direct valid", 64'(out_valid6), 64'h1);
        step();
        start6 = 1'b1; mode6 = 1'b1;
        step();
        start6 = 1'b0; mode6 = 1'b0;
        checkOutput("w6 scan busy", 64'(busy6), 64'h1);
        step();
        step();
        checkOutput("w6 scan early valid", 64'(out_valid6), 64'h0);
        for (int k = 0; k < 64; k++) begin
            step();
            checkOutput($sformatf("w6 scan y %0d", k), y6, 64'd1 << k);
            checkOutput($sformatf("w6 scan done %0d", k), 64'(done6), 64'(k == 63));
        end
        checkOutput("w6 scan busy end", 64'(busy6), 64'h0);
        step();
        checkOutput("w6 scan valid end", 64'(out_valid6), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
